// File: rtl/keccak_sponge_ctrl_pkg.sv
// keccak_sponge_ctrl_pkg: sponge controller states, round count and default geometry
package keccak_sponge_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, ABSORB, PERM_LAUNCH, PERM_WAIT, SQUEEZE} state_t;
  localparam int ROUNDS = 18;
  localparam int DEF_RATE_WORDS = 18;
  localparam int DEF_SQUEEZE_WORDS = 4;
  localparam int DEF_PERM_TIMEOUT = 24;
endpackage

// File: rtl/keccak_sponge_ctrl_word_counter.sv
// sponge_word_counter: word index (Clear -> 0, Inc -> +1, back to 0 after TermIdx), Terminal when Count == TermIdx
module sponge_word_counter
  import keccak_sponge_ctrl_pkg::*;
#(
  parameter int IW = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Inc,
  input  logic [IW-1:0] TermIdx,
  output logic [IW-1:0] Count,
  output logic          Terminal
);
  assign Terminal = Count == TermIdx;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) Count <= '0;
    else if (Clear || (Inc && Terminal)) Count <= '0;
    else if (Inc) Count <= Count + 1'b1;
endmodule

// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl: absorb/permute/squeeze sequencer; Start/InValid/InLast/PermReady/OutReady in, InReady/AbsorbEn/StateClear/WordIdx/PermReset/OutValid/Busy/Done/Error out
module keccak_sponge_ctrl
  import keccak_sponge_ctrl_pkg::*;
#(
  parameter int W = 8,
  parameter int RATE_WORDS = DEF_RATE_WORDS,
  parameter int SQUEEZE_WORDS = DEF_SQUEEZE_WORDS,
  parameter int PERM_TIMEOUT = DEF_PERM_TIMEOUT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic InValid,
  output logic InReady,
  input  logic InLast,
  output logic AbsorbEn,
  output logic StateClear,
  output logic [(RATE_WORDS > 1 ? $clog2(RATE_WORDS) : 1)-1:0] WordIdx,
  output logic PermReset,
  input  logic PermReady,
  output logic OutValid,
  input  logic OutReady,
  output logic Busy,
  output logic Done,
  output logic Error
);
  localparam int IW = RATE_WORDS > 1 ? $clog2(RATE_WORDS) : 1;
  localparam int TW = $clog2(PERM_TIMEOUT + 1);
  if (W * 25 != 200 || SQUEEZE_WORDS < 1 || SQUEEZE_WORDS > RATE_WORDS) begin : g_bad_params
    $error("keccak_sponge_ctrl: unsupported parameters");
  end
  state_t state, nextState;
  logic lastFlag, cntClear, cntInc, terminal, timeout;
  logic [TW-1:0] permCycles;
  logic [IW-1:0] termIdx;
  assign termIdx = state == SQUEEZE ? IW'(SQUEEZE_WORDS - 1) : IW'(RATE_WORDS - 1);
  assign timeout = state == PERM_WAIT && !PermReady && permCycles == TW'(PERM_TIMEOUT - 1);
  sponge_word_counter #(.IW(IW)) uWordCounter (
    .Clock(Clock),
    .Reset(Reset),
    .Clear(cntClear),
    .Inc(cntInc),
    .TermIdx(termIdx),
    .Count(WordIdx),
    .Terminal(terminal)
  );
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      lastFlag <= 1'b0;
      permCycles <= '0;
      Done <= 1'b0;
      Error <= 1'b0;
    end else begin
      state <= nextState;
      Done <= state == SQUEEZE && OutReady && terminal;
      permCycles <= state == PERM_WAIT ? permCycles + 1'b1 : '0;
      if (AbsorbEn && terminal) lastFlag <= InLast;
      if (state == IDLE && Start) Error <= 1'b0;
      else if (timeout) Error <= 1'b1;
    end
  always_comb begin
    nextState = state;
    InReady = state == ABSORB;
    AbsorbEn = InReady && InValid;
    OutValid = state == SQUEEZE;
    StateClear = state == CLEAR;
    PermReset = state != PERM_WAIT;
    Busy = state != IDLE;
    cntClear = StateClear || (state == PERM_WAIT && PermReady);
    cntInc = AbsorbEn || (OutValid && OutReady);
    case (state)
      IDLE:        nextState = Start ? CLEAR : IDLE;
      CLEAR:       nextState = ABSORB;
      ABSORB:      nextState = AbsorbEn && terminal ? PERM_LAUNCH : ABSORB;
      PERM_LAUNCH: nextState = PERM_WAIT;
      PERM_WAIT:   nextState = PermReady ? (lastFlag ? SQUEEZE : ABSORB) : timeout ? IDLE : PERM_WAIT;
      SQUEEZE:     nextState = OutReady && terminal ? IDLE : SQUEEZE;
      default:     nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// tb_keccak_sponge_ctrl: directed checks of the sponge controller against a simple round-controller model
module tb_keccak_sponge_ctrl;
  localparam int RATE = 18;
  localparam int SQ = 4;
  localparam int PERM_DELAY = 19;
  logic Clock = 1'b0, Reset = 1'b1, Start = 1'b0, InValid = 1'b0, InLast = 1'b0, OutReady = 1'b0;
  logic InReady, AbsorbEn, StateClear, PermReset, PermReady, OutValid, Busy, Done, Error;
  logic [4:0] WordIdx;
  logic permEnable = 1'b1;
  logic [7:0] permCnt;
  int checks = 0, errors = 0;
  int clearCnt = 0, absorbCnt = 0, doneCnt = 0, permFalls = 0, overlapCnt = 0;
  logic prevPermReset = 1'b1;
  int s0Clear, s0Absorb, s0Done, s0Falls;

  keccak_sponge_ctrl dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(InReady),
    .InLast(InLast), .AbsorbEn(AbsorbEn), .StateClear(StateClear), .WordIdx(WordIdx),
    .PermReset(PermReset), .PermReady(PermReady), .OutValid(OutValid), .OutReady(OutReady),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock or posedge Reset)
    if (Reset || PermReset) permCnt <= 8'd0;
    else if (permCnt != 8'hff) permCnt <= permCnt + 8'd1;
  assign PermReady = permEnable && permCnt >= 8'(PERM_DELAY);

  always @(posedge Clock) begin
    if (!Reset) begin
      clearCnt += int'(StateClear);
      absorbCnt += int'(AbsorbEn);
      doneCnt += int'(Done);
      permFalls += int'(prevPermReset && !PermReset);
      overlapCnt += int'((InReady || AbsorbEn) && OutValid);
    end
    prevPermReset = PermReset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic snap();
    s0Clear = clearCnt;
    s0Absorb = absorbCnt;
    s0Done = doneCnt;
    s0Falls = permFalls;
  endtask

  task automatic startHash();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("clear_pulse", StateClear, 1);
    check("clear_no_ready", InReady, 0);
    tick();
    check("start_to_ready", InReady, 1);
    check("clear_idx", WordIdx, 0);
  endtask

  task automatic sendWords(input int from, input int to, input logic last, input logic gap);
    int n;
    for (int i = from; i <= to; i++) begin
      n = 0;
      while (!InReady && n < 100) begin
        tick();
        n++;
      end
      check("in_ready_wait", InReady, 1);
      check("absorb_idx", WordIdx, i);
      InValid = 1'b1;
      InLast = (i == RATE - 1) ? last : (i == 5);
      tick();
      InValid = 1'b0;
      InLast = 1'b0;
      if (gap && i < RATE - 1) begin
        tick();
        check("gap_hold_idx", WordIdx, i + 1);
      end
    end
  endtask

  task automatic squeezeWords(input int from, input int to);
    int n;
    for (int j = from; j <= to; j++) begin
      n = 0;
      while (!OutValid && n < 100) begin
        tick();
        n++;
      end
      check("out_valid_wait", OutValid, 1);
      check("squeeze_idx", WordIdx, j);
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
    end
  endtask

  task automatic finishHash();
    check("done_pulse", Done, 1);
    check("done_idle", Busy, 0);
    tick();
    check("done_one_cycle", Done, 0);
  endtask

  initial begin
    int n, m;
    tick();
    tick();
    check("rst_in_ready", InReady, 0);
    check("rst_absorb", AbsorbEn, 0);
    check("rst_clear", StateClear, 0);
    check("rst_idx", WordIdx, 0);
    check("rst_perm_reset", PermReset, 1);
    check("rst_out_valid", OutValid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    Reset = 1'b0;

    snap();
    startHash();
    sendWords(0, RATE - 1, 1'b1, 1'b0);
    check("launch_perm_reset_high", PermReset, 1);
    tick();
    check("perm_reset_low_2cyc", PermReset, 0);
    squeezeWords(0, SQ - 1);
    finishHash();
    check("single_clear_pulses", clearCnt - s0Clear, 1);
    check("single_absorb_pulses", absorbCnt - s0Absorb, RATE);
    check("single_done_pulses", doneCnt - s0Done, 1);
    check("single_perm_windows", permFalls - s0Falls, 1);

    snap();
    startHash();
    sendWords(0, RATE - 1, 1'b0, 1'b0);
    sendWords(0, RATE - 1, 1'b1, 1'b0);
    n = 0;
    while (!OutValid && n < 100) begin
      tick();
      n++;
    end
    check("two_absorb_pulses", absorbCnt - s0Absorb, 2 * RATE);
    squeezeWords(0, SQ - 1);
    finishHash();
    check("two_perm_windows", permFalls - s0Falls, 2);

    startHash();
    sendWords(0, RATE - 1, 1'b1, 1'b1);
    n = 0;
    while (!OutValid && n < 100) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check("bp_idx_hold", WordIdx, 0);
    check("bp_out_valid", OutValid, 1);
    check("bp_no_error", Error, 0);
    squeezeWords(0, SQ - 1);
    finishHash();

    snap();
    permEnable = 1'b0;
    startHash();
    sendWords(0, RATE - 1, 1'b1, 1'b0);
    n = 0;
    while (PermReset && n < 10) begin
      tick();
      n++;
    end
    m = 0;
    while (!PermReset && m < 100) begin
      m++;
      tick();
    end
    check("timeout_cycles", m, 24);
    check("timeout_error", Error, 1);
    check("timeout_idle", Busy, 0);
    tick();
    check("timeout_no_done", doneCnt - s0Done, 0);
    check("timeout_error_sticky", Error, 1);
    permEnable = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_clears_error", Error, 0);
    tick();
    sendWords(0, RATE - 1, 1'b1, 1'b0);
    squeezeWords(0, SQ - 1);
    finishHash();

    snap();
    startHash();
    sendWords(0, 6, 1'b0, 1'b0);
    check("pre_reset_idx", WordIdx, 7);
    InValid = 1'b1;
    Reset = 1'b1;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_idx", WordIdx, 0);
    check("mid_rst_in_ready", InReady, 0);
    check("mid_rst_absorb", AbsorbEn, 0);
    check("mid_rst_perm_reset", PermReset, 1);
    tick();
    Reset = 1'b0;
    InValid = 1'b0;
    startHash();
    sendWords(0, RATE - 1, 1'b1, 1'b0);
    squeezeWords(0, SQ - 1);
    check("post_rst_done_count", doneCnt - s0Done, 0);
    finishHash();

    startHash();
    sendWords(0, 4, 1'b0, 1'b0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_in_absorb_idx", WordIdx, 5);
    check("start_in_absorb_ready", InReady, 1);
    check("start_in_absorb_no_clear", StateClear, 0);
    sendWords(5, RATE - 1, 1'b1, 1'b0);
    squeezeWords(0, 0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_in_squeeze_idx", WordIdx, 1);
    check("start_in_squeeze_valid", OutValid, 1);
    squeezeWords(1, SQ - 1);
    finishHash();
    check("no_overlap", overlapCnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keccak_sponge_ctrl.md
KECCAK_SPONGE_CTRL -- requirements
Module: keccak_sponge_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, giving the lane/word width of the Keccak-f[200] datapath.
REQ-002 SHALL have parameter RATE_WORDS, default 18, giving the number of W-bit words absorbed per block.
REQ-003 SHALL have parameter SQUEEZE_WORDS, default 4, giving the number of words output per hash, limited to 1..RATE_WORDS.
REQ-004 SHALL have parameter PERM_TIMEOUT, default 24, giving the maximum number of PERM_WAIT cycles before an error is raised.
REQ-005 SHALL have port Clock, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port Start, input, 1 bit: begin a new hash (sampled in IDLE only).
REQ-008 SHALL have port InValid, input, 1 bit: a message word is present.
REQ-009 SHALL have port InReady, output, 1 bit: the controller accepts a message word.
REQ-010 SHALL have port InLast, input, 1 bit: the current block is final (sampled only with word RATE_WORDS-1).
REQ-011 SHALL have port AbsorbEn, output, 1 bit: XOR the input word into state lane WordIdx this cycle.
REQ-012 SHALL have port StateClear, output, 1 bit: zero the state register.
REQ-013 SHALL have port WordIdx, output, clog2(RATE_WORDS) bits: the current absorb/squeeze word index.
REQ-014 SHALL have port PermReset, output, 1 bit: drives the round-controller reset (high = held in START).
REQ-015 SHALL have port PermReady, input, 1 bit: round-controller Ready.
REQ-016 SHALL have port OutValid, output, 1 bit: squeeze word valid at lane WordIdx.
REQ-017 SHALL have port OutReady, input, 1 bit: the consumer accepts the squeeze word.
REQ-018 SHALL have port Busy, output, 1 bit: high in any state other than IDLE.
REQ-019 SHALL have port Done, output, 1 bit: one-cycle pulse after the final squeeze word.
REQ-020 SHALL have port Error, output, 1 bit: sticky permutation timeout.

Function
REQ-021 SHALL implement the states IDLE, CLEAR, ABSORB, PERM_LAUNCH, PERM_WAIT and SQUEEZE.
REQ-022 IDLE: on Start=1, SHALL go to CLEAR and clear Error; Start SHALL be ignored in every other state.
REQ-023 CLEAR: SHALL assert StateClear for exactly 1 cycle, set WordIdx=0, then go to ABSORB.
REQ-024 ABSORB: SHALL hold InReady=1 and set AbsorbEn=InValid&InReady combinationally; WordIdx SHALL increment on each accepted word.
REQ-025 When word RATE_WORDS-1 is accepted, SHALL latch LastFlag=InLast and go to PERM_LAUNCH; InLast on any other word SHALL be ignored.
REQ-026 PERM_LAUNCH: SHALL keep PermReset=1 for 1 cycle, then go to PERM_WAIT.
REQ-027 PERM_WAIT: SHALL drive PermReset=0 and count cycles; PermReset SHALL be 1 in every other state.
REQ-028 On PermReady=1, SHALL reset WordIdx to 0 and go to SQUEEZE if LastFlag=1, otherwise back to ABSORB.
REQ-029 If PERM_TIMEOUT cycles elapse in PERM_WAIT without PermReady, SHALL set Error=1 and go to IDLE with no Done pulse.
REQ-030 SQUEEZE: SHALL hold OutValid=1; WordIdx SHALL increment on OutValid&OutReady.
REQ-031 On the transfer of word SQUEEZE_WORDS-1, SHALL go to IDLE, with Done=1 for the following cycle only.
REQ-032 InReady, AbsorbEn and OutValid SHALL never be high simultaneously, and SHALL all be 0 outside their states.
REQ-033 WordIdx SHALL never exceed RATE_WORDS-1: it resets at block boundaries and does not wrap.
REQ-034 If InValid=0 or OutReady=0, the controller SHALL stall indefinitely with no timeout.
REQ-035 Latencies: Start-to-InReady SHALL be 2 cycles; last-word-to-PermReset-low SHALL be 2 cycles.

Reset
REQ-036 Reset=1 SHALL asynchronously force: state IDLE, WordIdx=0, LastFlag=0, timeout counter=0, InReady=0, AbsorbEn=0, StateClear=0, OutValid=0, PermReset=1, Busy=0, Done=0, Error=0.
REQ-037 Reset asserted mid-hash SHALL abandon the operation, with no Done pulse after release.
REQ-038 The first Start after reset release SHALL be honoured in the first clock cycle.

Structure
REQ-039 A shared package SHALL hold the state enumeration, ROUNDS=18, and the default RATE_WORDS, SQUEEZE_WORDS and PERM_TIMEOUT.
REQ-040 The sub-module sponge_word_counter (load-zero/increment counter with terminal flag) SHALL be shared by the absorb and squeeze phases.
REQ-041 The round controller SHALL be instantiated by the parent, not inside this block.

Verification
REQ-042 Single block: Start, 18 words, InLast=1 on word 17, PermReady 19 cycles after PermReset falls, OutReady=1 -> 4 OutValid beats with WordIdx 0..3, Done 1 cycle later, 1 StateClear pulse.
REQ-043 Two blocks: InLast=1 only on block 2 -> exactly 2 PermReset low windows, with 36 AbsorbEn pulses before SQUEEZE.
REQ-044 Backpressure: InValid toggling 1/0 and OutReady held 0 for 10 cycles -> WordIdx holds, OutValid stays 1, no Error.
REQ-045 Timeout: PermReady held 0 -> Error=1 after 24 PERM_WAIT cycles, IDLE, Busy=0, no Done; a subsequent Start clears Error.
REQ-046 Reset at word 7 of ABSORB -> immediate IDLE with all outputs at reset values; a new hash then completes normally.
REQ-047 Start pulsed during ABSORB and SQUEEZE -> no effect on state or WordIdx.
